// File: rtl/axis_arbiter_pkg.sv
// Shared constants and helpers for the axis_arbiter family: arbitration type and
// priority-direction encodings, plus a ceil-log2 helper for index widths.
package axis_arbiter_pkg;

    typedef enum logic [0:0] {
        ArbFixed      = 1'b0,
        ArbRoundRobin = 1'b1
    } arb_type_e;

    typedef enum logic [0:0] {
        PrioMsbHigh = 1'b0,
        PrioLsbHigh = 1'b1
    } prio_dir_e;

    localparam int ArbTypeFixed      = 0;
    localparam int ArbTypeRoundRobin = 1;
    localparam int PrioDirMsbHigh    = 0;
    localparam int PrioDirLsbHigh    = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_arbiter_prio_enc.sv
// Priority encoder: picks the highest-priority set bit of in_i, lowest index wins when
// LsbHighPriority is set, highest index otherwise. Reports index, valid and one-hot.
module axis_arbiter_prio_enc
    import axis_arbiter_pkg::*;
#(
    parameter int unsigned Width           = 4,
    parameter bit          LsbHighPriority = 1'b0,
    localparam int unsigned IdxW           = clog2(Width)
) (
    input  logic [Width-1:0] in_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             valid_o,
    output logic [Width-1:0] onehot_o
);

    logic [IdxW-1:0] idx;
    logic            found;

    // LSB-high keeps the first hit; MSB-high lets later (higher) hits overwrite.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(Width); i++) begin
            if (in_i[i]) begin
                if (!LsbHighPriority || !found) begin
                    idx = IdxW'(i);
                end
                found = 1'b1;
            end
        end
    end

    always_comb begin
        onehot_o = '0;
        if (found) begin
            onehot_o[idx] = 1'b1;
        end
    end

    assign idx_o   = idx;
    assign valid_o = found;

endmodule

// File: rtl/axis_arbiter.sv
// N-port arbiter with registered one-hot/encoded grant, fixed or round-robin priority
// and optional grant blocking. Define AXIS_ARBITER_ASSERT_EN for simulation checks.
module axis_arbiter
    import axis_arbiter_pkg::*;
#(
    parameter int PORTS                 = 4,
    parameter int ARB_TYPE_ROUND_ROBIN  = ArbTypeFixed,
    parameter int ARB_BLOCK             = 0,
    parameter int ARB_BLOCK_ACK         = 1,
    parameter int ARB_LSB_HIGH_PRIORITY = PrioDirMsbHigh,
    localparam int IdxW                 = clog2(PORTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] request,
    input  logic [PORTS-1:0] acknowledge,
    output logic [PORTS-1:0] grant,
    output logic             grant_valid,
    output logic [IdxW-1:0]  grant_encoded
);

    localparam bit RoundRobin = (ARB_TYPE_ROUND_ROBIN == ArbTypeRoundRobin);
    localparam bit LsbHigh    = (ARB_LSB_HIGH_PRIORITY == PrioDirLsbHigh);
    localparam bit Block      = (ARB_BLOCK != 0);
    localparam bit BlockAck   = (ARB_BLOCK_ACK != 0);

    logic [PORTS-1:0] grant_q, grant_d;
    logic             grant_valid_q, grant_valid_d;
    logic [IdxW-1:0]  grant_encoded_q, grant_encoded_d;
    logic [PORTS-1:0] mask_q, mask_d;

    logic [PORTS-1:0] req_masked;
    logic [IdxW-1:0]  req_idx, masked_idx, win_idx;
    logic             req_valid, masked_valid;
    logic [PORTS-1:0] req_onehot, masked_onehot, win_onehot;
    logic             hold_drop, hold_ack, hold;

    assign req_masked = request & mask_q;

    axis_arbiter_prio_enc #(
        .Width           (PORTS),
        .LsbHighPriority (LsbHigh)
    ) u_enc_req (
        .in_i     (request),
        .idx_o    (req_idx),
        .valid_o  (req_valid),
        .onehot_o (req_onehot)
    );

    axis_arbiter_prio_enc #(
        .Width           (PORTS),
        .LsbHighPriority (LsbHigh)
    ) u_enc_masked (
        .in_i     (req_masked),
        .idx_o    (masked_idx),
        .valid_o  (masked_valid),
        .onehot_o (masked_onehot)
    );

    assign hold_drop = Block && !BlockAck && (|(grant_q & request));
    assign hold_ack  = Block && BlockAck && grant_valid_q && !(|(grant_q & acknowledge));
    assign hold      = hold_drop || hold_ack;

    // Round robin prefers requesters past the last winner, falling back to raw priority.
    always_comb begin
        if (RoundRobin && masked_valid) begin
            win_idx    = masked_idx;
            win_onehot = masked_onehot;
        end else begin
            win_idx    = req_idx;
            win_onehot = req_onehot;
        end
    end

    always_comb begin
        grant_d         = grant_q;
        grant_valid_d   = grant_valid_q;
        grant_encoded_d = grant_encoded_q;
        mask_d          = mask_q;
        if (hold) begin
            grant_d = grant_q;
        end else if (req_valid) begin
            grant_d         = win_onehot;
            grant_valid_d   = 1'b1;
            grant_encoded_d = win_idx;
            if (RoundRobin) begin
                // Last winner and everything ahead of it drop behind the rest.
                for (int j = 0; j < PORTS; j++) begin
                    mask_d[j] = LsbHigh ? (j > int'(win_idx)) : (j < int'(win_idx));
                end
            end
        end else begin
            grant_d         = '0;
            grant_valid_d   = 1'b0;
            grant_encoded_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q         <= '0;
            grant_valid_q   <= 1'b0;
            grant_encoded_q <= '0;
            mask_q          <= '0;
        end else begin
            grant_q         <= grant_d;
            grant_valid_q   <= grant_valid_d;
            grant_encoded_q <= grant_encoded_d;
            mask_q          <= mask_d;
        end
    end

    assign grant         = grant_q;
    assign grant_valid   = grant_valid_q;
    assign grant_encoded = grant_encoded_q;

`ifdef AXIS_ARBITER_ASSERT_EN
    logic             chk_hold_q;
    logic [PORTS-1:0] chk_grant_q;
    logic [IdxW-1:0]  chk_enc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_hold_q  <= 1'b0;
            chk_grant_q <= '0;
        end else begin
            chk_hold_q  <= hold;
            chk_grant_q <= grant_q;
        end
    end

    always_comb begin
        chk_enc = '0;
        for (int k = 0; k < PORTS; k++) begin
            if (grant_q[k]) begin
                chk_enc = IdxW'(k);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(grant_q))
                else $error("axis_arbiter: grant not one-hot %0h", grant_q);
            assert (grant_valid_q == (|grant_q))
                else $error("axis_arbiter: grant_valid inconsistent with grant");
            assert (grant_encoded_q == chk_enc)
                else $error("axis_arbiter: grant_encoded %0d vs grant %0h",
                            grant_encoded_q, grant_q);
            if (chk_hold_q) begin
                assert (grant_q == chk_grant_q)
                    else $error("axis_arbiter: held grant changed");
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_arbiter.sv
// Self-checking bench: four arbiter configurations driven by directed and random
// stimulus, compared each cycle against a behavioural scan-order model.
module tb_axis_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // d_fix: 32 ports, fixed, block until drop, MSB high
    logic [31:0] req_f, ack_f, gnt_f;
    logic        vld_f;
    logic [4:0]  enc_f;
    // d_rr: 4 ports, round robin, non-blocking, LSB high
    logic [3:0]  req_r, ack_r, gnt_r;
    logic        vld_r;
    logic [1:0]  enc_r;
    // d_ack: 4 ports, fixed, block until acknowledge, LSB high
    logic [3:0]  req_a, ack_a, gnt_a;
    logic        vld_a;
    logic [1:0]  enc_a;
    // d_rrb: 8 ports, round robin, block until drop, MSB high
    logic [7:0]  req_b, ack_b, gnt_b;
    logic        vld_b;
    logic [2:0]  enc_b;

    axis_arbiter #(.PORTS(32), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
                   .ARB_LSB_HIGH_PRIORITY(0)) d_fix (
        .clk(clk), .rst(rst), .request(req_f), .acknowledge(ack_f),
        .grant(gnt_f), .grant_valid(vld_f), .grant_encoded(enc_f));

    axis_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1),
                   .ARB_LSB_HIGH_PRIORITY(1)) d_rr (
        .clk(clk), .rst(rst), .request(req_r), .acknowledge(ack_r),
        .grant(gnt_r), .grant_valid(vld_r), .grant_encoded(enc_r));

    axis_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
                   .ARB_LSB_HIGH_PRIORITY(1)) d_ack (
        .clk(clk), .rst(rst), .request(req_a), .acknowledge(ack_a),
        .grant(gnt_a), .grant_valid(vld_a), .grant_encoded(enc_a));

    axis_arbiter #(.PORTS(8), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
                   .ARB_LSB_HIGH_PRIORITY(0)) d_rrb (
        .clk(clk), .rst(rst), .request(req_b), .acknowledge(ack_b),
        .grant(gnt_b), .grant_valid(vld_b), .grant_encoded(enc_b));

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: granted index (-1 idle) and last round-robin winner (-1 none).
    int g_f = -1, l_f = -1;
    int g_r = -1, l_r = -1;
    int g_a = -1, l_a = -1;
    int g_b = -1, l_b = -1;

    task automatic model(input int ports, input int rr, input int blk, input int ackm,
                         input int lsb, input logic [31:0] req, input logic [31:0] ackv,
                         input int g_in, input int last_in,
                         output int g_out, output int last_out);
        int found;
        int idx;
        g_out    = g_in;
        last_out = last_in;
        if (blk != 0 && ackm == 0 && g_in >= 0 && req[g_in]) return;
        if (blk != 0 && ackm != 0 && g_in >= 0 && !ackv[g_in]) return;
        if (req == 32'd0) begin
            g_out = -1;
            return;
        end
        found = -1;
        if (rr != 0 && last_in >= 0) begin
            // Scan starting just past the last winner in priority order, wrapping.
            for (int k = 1; k <= ports; k++) begin
                idx = (lsb != 0) ? (last_in + k) % ports : (last_in - k + ports) % ports;
                if (found < 0 && req[idx]) found = idx;
            end
        end
        if (found < 0) begin
            for (int i = 0; i < ports; i++) begin
                if (req[i] && (lsb == 0 || found < 0)) found = i;
            end
        end
        g_out = found;
        if (rr != 0) last_out = found;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(input string tag, input logic [31:0] gnt, input logic vld,
                            input logic [31:0] enc, input int g);
        chk({tag, ".grant"}, gnt, (g >= 0) ? (32'd1 << g) : 32'd0);
        chk({tag, ".valid"}, {31'd0, vld}, (g >= 0) ? 32'd1 : 32'd0);
        chk({tag, ".encoded"}, enc, (g >= 0) ? 32'(g) : 32'd0);
    endtask

    task automatic check_all();
        chk_inst("fix", gnt_f, vld_f, 32'(enc_f), g_f);
        chk_inst("rr", 32'(gnt_r), vld_r, 32'(enc_r), g_r);
        chk_inst("ack", 32'(gnt_a), vld_a, 32'(enc_a), g_a);
        chk_inst("rrb", 32'(gnt_b), vld_b, 32'(enc_b), g_b);
    endtask

    task automatic tick();
        int ng, nl;
        model(32, 0, 1, 0, 0, req_f, ack_f, g_f, l_f, ng, nl);
        g_f = ng; l_f = nl;
        model(4, 1, 0, 1, 1, 32'(req_r), 32'(ack_r), g_r, l_r, ng, nl);
        g_r = ng; l_r = nl;
        model(4, 0, 1, 1, 1, 32'(req_a), 32'(ack_a), g_a, l_a, ng, nl);
        g_a = ng; l_a = nl;
        model(8, 1, 1, 0, 0, 32'(req_b), 32'(ack_b), g_b, l_b, ng, nl);
        g_b = ng; l_b = nl;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic model_reset();
        g_f = -1; l_f = -1; g_r = -1; l_r = -1;
        g_a = -1; l_a = -1; g_b = -1; l_b = -1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req_f = '0; ack_f = '0; req_r = '0; ack_r = '0;
        req_a = '0; ack_a = '0; req_b = '0; ack_b = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Fixed priority, block-until-drop, MSB high
        req_f = 32'h0000_0001; tick();
        chk("fix_single", gnt_f, 32'h0000_0001);
        chk("fix_single_enc", 32'(enc_f), 32'd0);
        req_f = 32'h0; tick();
        chk("fix_idle", gnt_f, 32'h0);
        req_f = 32'h0000_0021; tick();
        chk("fix_prio", gnt_f, 32'h0000_0020);
        chk("fix_prio_enc", 32'(enc_f), 32'd5);
        req_f = 32'h8000_0021; tick();
        chk("fix_hold1", gnt_f, 32'h0000_0020);
        tick();
        chk("fix_hold2", gnt_f, 32'h0000_0020);
        req_f = 32'h8000_0001; tick();
        chk("fix_drop", gnt_f, 32'h8000_0000);
        chk("fix_drop_enc", 32'(enc_f), 32'd31);
        req_f = 32'h0; tick();
        chk("fix_zero_valid", {31'd0, vld_f}, 32'd0);

        // Round robin, LSB high, all requesting
        req_r = 4'hF;
        tick(); chk("rr_0", 32'(gnt_r), 32'h1);
        tick(); chk("rr_1", 32'(gnt_r), 32'h2);
        tick(); chk("rr_2", 32'(gnt_r), 32'h4);
        tick(); chk("rr_3", 32'(gnt_r), 32'h8);
        tick(); chk("rr_4", 32'(gnt_r), 32'h1);
        req_r = 4'h0; tick();

        // Acknowledge release
        req_a = 4'h4; tick();
        chk("ack_grant", 32'(gnt_a), 32'h4);
        req_a = 4'h3;
        repeat (3) begin
            tick();
            chk("ack_hold", 32'(gnt_a), 32'h4);
        end
        ack_a = 4'h4; tick();
        chk("ack_release", 32'(gnt_a), 32'h1);
        ack_a = 4'h2; req_a = 4'h0; tick();
        chk("ack_wrong_bit", 32'(gnt_a), 32'h1);
        ack_a = 4'h1; tick();
        chk("ack_to_idle", 32'(gnt_a), 32'h0);
        ack_a = 4'h0;

        // Random traffic on all four configurations
        for (int i = 0; i < 400; i++) begin
            req_f = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 7) == 0) req_f = '0;
            ack_f = $urandom;
            req_r = 4'($urandom);
            ack_r = 4'($urandom);
            req_a = 4'($urandom);
            ack_a = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            req_b = 8'($urandom & $urandom);
            ack_b = 8'($urandom);
            tick();
        end

        // Reset in the middle of active grants
        req_f = 32'h0000_00F0; req_r = 4'hF; req_a = 4'hF; req_b = 8'hFF;
        ack_f = '0; ack_r = '0; ack_a = '0; ack_b = '0;
        tick();
        chk("pre_rst_valid", {31'd0, vld_f}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #2;
        rst = 1'b0;
        req_f = 32'h0000_000A; req_r = 4'hF; req_a = 4'h0; req_b = 8'h0;
        tick();
        chk("post_rst_fix", gnt_f, 32'h0000_0008);
        chk("post_rst_fix_enc", 32'(enc_f), 32'd3);
        chk("post_rst_rr", 32'(gnt_r), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
